// File: rtl/flappy_game_ctrl.sv
//------------------------------------------------------------------------------
// Module      : flappy_game_ctrl
// Description : Frame-rate game engine for flappy-bird. Advances the bird,
//               three wrapping pipes, the score and the IDLE/PLAY/OVER/WIN
//               phase once per frame_tick. All outputs are registered.
//               Optional macro PIPE_COLLISION_EN: when defined, touching a
//               pipe ends the game; otherwise only ceiling/floor do.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module flappy_game_ctrl #(
    parameter int BIRD_X       = 300,
    parameter int PIPE_SPEED   = 4,
    parameter int GRAVITY      = 1,
    parameter int FLAP_VEL     = 10,
    parameter int VMAX         = 12,
    parameter int PIPE_SPACING = 448,
    parameter int WIN_SCORE    = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_tick,
    input  logic        btn_flap,
    input  logic        btn_start,
    output logic [11:0] bpos_x,
    output logic [11:0] bpos_y,
    output logic [11:0] pippos_x1,
    output logic [11:0] pippos_x2,
    output logic [11:0] pippos_x3,
    output logic [11:0] pippos_y1,
    output logic [11:0] pippos_y2,
    output logic [11:0] pippos_y3,
    output logic [3:0]  score,
    output logic        is_start,
    output logic        is_over,
    output logic        is_win
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_PLAY = 2'd1;
    localparam logic [1:0] c_OVER = 2'd2;
    localparam logic [1:0] c_WIN  = 2'd3;

    localparam logic [11:0]       c_Y_RST     = 12'd360;
    localparam logic [11:0]       c_Y_MIN     = 12'd50;
    localparam logic [11:0]       c_Y_MAX     = 12'd670;
    localparam logic [11:0]       c_PIPE_X0   = 12'd900;
    localparam logic [11:0]       c_BIRD_X    = 12'(BIRD_X);
    localparam logic [11:0]       c_SPEED     = 12'(PIPE_SPEED);
    localparam logic [11:0]       c_WRAP_ADD  = 12'(3 * PIPE_SPACING - PIPE_SPEED);
    localparam logic [11:0]       c_SCORE_X   = 12'(BIRD_X - 136);
    localparam logic signed [7:0] c_FLAP_VEL  = 8'(-FLAP_VEL);
    localparam logic signed [7:0] c_GRAVITY   = 8'(GRAVITY);
    localparam logic signed [7:0] c_VMAX      = 8'(VMAX);
    localparam logic [3:0]        c_WIN_SCORE = 4'(WIN_SCORE);
    localparam logic [15:0]       c_LFSR_SEED = 16'hACE1;

    logic [1:0]        r_state;
    logic              r_start_d, r_flap_d, r_start_rise, r_flap_rise;
    logic              r_flap_pend;
    logic [15:0]       r_lfsr;
    logic              r_eval;
    logic              r_clamp_hit;
    logic signed [7:0] r_vel;
    logic [11:0]       r_by;
    logic [11:0]       r_px [3];
    logic [11:0]       r_py [3];
    logic [3:0]        r_score;

    logic              w_play, w_step, w_reload, w_pipe_hit;
    logic signed [7:0] w_vel_grav, w_vel_next;
    logic signed [12:0] w_y_sum;
    logic [11:0]       w_y_next;
    logic              w_clamp;
    logic [8:0]        w_gap_r;
    logic [11:0]       w_gap_new;
    logic [11:0]       w_px_next [3];
    logic [11:0]       w_py_next [3];
    logic [2:0]        w_cross;
    logic [3:0]        w_score_next;

    assign w_play   = (r_state == c_PLAY);
    assign w_step   = frame_tick && w_play;
    assign w_reload = ((r_state == c_OVER) || (r_state == c_WIN)) && r_start_rise;

    // Bird physics: flap or gravity with terminal velocity, then clamp y
    always_comb begin
        w_vel_grav = r_vel + c_GRAVITY;
        if (r_flap_pend) begin
            w_vel_next = c_FLAP_VEL;
        end else if (w_vel_grav > c_VMAX) begin
            w_vel_next = c_VMAX;
        end else begin
            w_vel_next = w_vel_grav;
        end
        w_y_sum  = $signed({1'b0, r_by}) + $signed({{5{w_vel_next[7]}}, w_vel_next});
        w_clamp  = 1'b0;
        w_y_next = w_y_sum[11:0];
        if (w_y_sum < 13'sd50) begin
            w_y_next = c_Y_MIN;
            w_clamp  = 1'b1;
        end else if (w_y_sum > 13'sd670) begin
            w_y_next = c_Y_MAX;
            w_clamp  = 1'b1;
        end
    end

    // Pipe motion, wrap-around with a fresh random gap, and score crossing
    always_comb begin
        w_gap_r   = (r_lfsr[8:0] > 9'd460) ? (r_lfsr[8:0] - 9'd256) : r_lfsr[8:0];
        w_gap_new = 12'd160 + {3'b000, w_gap_r};
        for (int i = 0; i < 3; i++) begin
            if (r_px[i] < c_SPEED) begin
                w_px_next[i] = r_px[i] + c_WRAP_ADD;
                w_py_next[i] = w_gap_new;
            end else begin
                w_px_next[i] = r_px[i] - c_SPEED;
                w_py_next[i] = r_py[i];
            end
            w_cross[i] = (r_px[i] >= c_SCORE_X) && (w_px_next[i] < c_SCORE_X);
        end
        w_score_next = ((|w_cross) && (r_score != 4'hF)) ? (r_score + 4'd1) : r_score;
    end

`ifdef PIPE_COLLISION_EN
    logic signed [12:0] w_by_s;
    logic signed [12:0] w_dx  [3];
    logic signed [12:0] w_adx [3];
    logic signed [12:0] w_gy  [3];

    // Bird box overlaps a pipe column but lies outside its gap
    always_comb begin
        w_pipe_hit = 1'b0;
        w_by_s     = $signed({1'b0, r_by});
        for (int i = 0; i < 3; i++) begin
            w_dx[i]  = $signed({1'b0, c_BIRD_X}) - $signed({1'b0, r_px[i]});
            w_adx[i] = (w_dx[i] < 13'sd0) ? -w_dx[i] : w_dx[i];
            w_gy[i]  = $signed({1'b0, r_py[i]});
            if ((w_adx[i] < 13'sd136) &&
                (((w_by_s - 13'sd50) < (w_gy[i] - 13'sd100)) ||
                 ((w_by_s + 13'sd50) > (w_gy[i] + 13'sd100)))) begin
                w_pipe_hit = 1'b1;
            end
        end
    end
`else
    assign w_pipe_hit = 1'b0;
`endif

    // Button edge detection (registered pulses) and free-running LFSR
    always_ff @(posedge clk) begin
        if (rst) begin
            r_start_d    <= 1'b0;
            r_flap_d     <= 1'b0;
            r_start_rise <= 1'b0;
            r_flap_rise  <= 1'b0;
            r_lfsr       <= c_LFSR_SEED;
            r_eval       <= 1'b0;
        end else begin
            r_start_d    <= btn_start;
            r_flap_d     <= btn_flap;
            r_start_rise <= btn_start && !r_start_d;
            r_flap_rise  <= btn_flap && !r_flap_d;
            r_lfsr       <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
            r_eval       <= w_step;
        end
    end

    // Pending flap: one per frame, only meaningful while playing
    always_ff @(posedge clk) begin
        if (rst || !w_play) begin
            r_flap_pend <= 1'b0;
        end else if (frame_tick) begin
            r_flap_pend <= r_flap_rise;
        end else if (r_flap_rise) begin
            r_flap_pend <= 1'b1;
        end
    end

    // Game phase; collision/win are judged the cycle after the frame update
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            case (r_state)
                c_IDLE: if (r_start_rise) r_state <= c_PLAY;
                c_PLAY: begin
                    if (r_eval) begin
                        if (w_pipe_hit || r_clamp_hit) begin
                            r_state <= c_OVER;
                        end else if (r_score >= c_WIN_SCORE) begin
                            r_state <= c_WIN;
                        end
                    end
                end
                default: if (r_start_rise) r_state <= c_IDLE;
            endcase
        end
    end

    // Object state: reloaded on reset/restart, advanced once per PLAY frame
    always_ff @(posedge clk) begin
        if (rst || w_reload) begin
            r_vel       <= 8'sd0;
            r_by        <= c_Y_RST;
            r_score     <= 4'd0;
            r_clamp_hit <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                r_px[i] <= c_PIPE_X0 + 12'(i * PIPE_SPACING);
                r_py[i] <= c_Y_RST;
            end
        end else if (w_step) begin
            r_vel       <= w_vel_next;
            r_by        <= w_y_next;
            r_score     <= w_score_next;
            r_clamp_hit <= w_clamp;
            for (int i = 0; i < 3; i++) begin
                r_px[i] <= w_px_next[i];
                r_py[i] <= w_py_next[i];
            end
        end
    end

    assign bpos_x    = c_BIRD_X;
    assign bpos_y    = r_by;
    assign pippos_x1 = r_px[0];
    assign pippos_x2 = r_px[1];
    assign pippos_x3 = r_px[2];
    assign pippos_y1 = r_py[0];
    assign pippos_y2 = r_py[1];
    assign pippos_y3 = r_py[2];
    assign score     = r_score;
    assign is_start  = (r_state != c_IDLE);
    assign is_over   = (r_state == c_OVER);
    assign is_win    = (r_state == c_WIN);

endmodule

`default_nettype wire

// File: doc/flappy_game_ctrl.md
# flappy_game_ctrl

Game-state and physics engine for the flappy-bird game. Once per video frame it advances the bird, the three pipes, the score and the game phase. It drives the bird/pipe coordinates, `score`, `is_start`, `is_over` and `is_win` straight into the pixel-colour stage. Coordinates are in the 1280×720 active-pixel space that the pixel stage scans.

## Interface
Parameters:
- `BIRD_X`, 300: fixed bird centre x.
- `PIPE_SPEED`, 4: pipe leftward step per frame, in px.
- `GRAVITY`, 1: velocity increment per frame.
- `FLAP_VEL`, 10: upward speed after a flap; velocity is set to −FLAP_VEL.
- `VMAX`, 12: maximum downward velocity.
- `PIPE_SPACING`, 448: x distance between adjacent pipes.
- `WIN_SCORE`, 10: score at which the game is won.

Ports:
- `clk` in 1: system clock.
- `rst` in 1: synchronous, active-high reset.
- `frame_tick` in 1: one-cycle pulse per frame, issued at start of vertical blanking.
- `btn_flap` in 1: debounced flap button, level.
- `btn_start` in 1: debounced start/restart button, level.
- `bpos_x`, `bpos_y` out 12: bird centre.
- `pippos_x1..3`, `pippos_y1..3` out 12 each: pipe centre x and gap centre y.
- `score` out 4: pipes passed.
- `is_start` out 1: high outside IDLE.
- `is_over` out 1: collision occurred.
- `is_win` out 1: score reached WIN_SCORE.

## Operation
- Phase FSM has four states: IDLE, PLAY, OVER, WIN.
  - IDLE → PLAY on a `btn_start` rising edge.
  - PLAY → OVER on a collision.
  - PLAY → WIN when `score` reaches WIN_SCORE.
  - OVER/WIN → IDLE on a `btn_start` rising edge. This transition also reloads all objects to their reset values.
- Both buttons are edge-detected internally with one register stage.
- A `btn_flap` rising edge sets a `flap_pend` flag. The flag is consumed and cleared at the next `frame_tick` in PLAY. Multiple presses within one frame count as one flap. `flap_pend` is cleared in every state other than PLAY.
- Bird update, on `frame_tick` in PLAY:
  - `vel` is an 8-bit signed register. It becomes −FLAP_VEL if a flap is pending. Otherwise it becomes min(vel+GRAVITY, VMAX).
  - The new y is y+vel, computed in 13-bit signed arithmetic.
  - If the new y < 50, y is clamped to 50 and a collision is flagged.
  - If the new y > 670, y is clamped to 670 and a collision is flagged.
- Pipe update, on `frame_tick` in PLAY:
  - Each pipe x is decremented by PIPE_SPEED.
  - If x < PIPE_SPEED before the step, the pipe wraps: x ← x + 3·PIPE_SPACING − PIPE_SPEED.
  - On wrap, the gap y is reloaded as 160 + r, where r = lfsr[8:0]. If r > 460, 256 is subtracted from r. The resulting gap y range is 160..620.
- LFSR:
  - 16-bit Fibonacci, taps 16/14/13/11, seed 16'hACE1.
  - It free-runs every cycle in all states, so the pipe pattern depends on the player's timing.
- Scoring: `score` increments, saturating, in the frame where a pipe's x goes from ≥ BIRD_X−136 to < BIRD_X−136.
- Pipe collision: a collision is flagged when both of the following hold:
  - |bpos_x − pipe_x| < 136.
  - bpos_y − 50 < gap_y − 100, or bpos_y + 50 > gap_y + 100.
- Simultaneous events: if a collision and the winning score land on the same frame, OVER has priority.
- IDLE, OVER and WIN freeze all positions. `frame_tick` is ignored in these states.

## Timing
- Reset values:
  - `bpos_x` = BIRD_X, `bpos_y` = 360, `vel` = 0.
  - `pippos_x1..3` = 900 / 1348 / 1796; `pippos_y1..3` = 360.
  - `score` = 0; `is_start`, `is_over`, `is_win` = 0.
  - LFSR = seed; FSM = IDLE.
- Cycle T is the cycle where `frame_tick` is sampled high.
  - Positions and `score` update at the T+1 edge.
  - Collision and win are evaluated on the T+1 registered values.
  - `is_over` / `is_win` assert at the T+2 edge.
- Outputs are registered and change only in these cycles. They are therefore stable throughout active video.
- `btn_start` edge → `is_start` changes 2 cycles after the button level rises (1 cycle for edge detect, 1 for the FSM).
- `rst` mid-frame overrides everything on the next edge, including a `frame_tick` in the same cycle.

## Configuration
- `PIPE_COLLISION_EN` defined (default build): pipe collisions end the game, as in Operation.
- Undefined: only ceiling/floor clamps set OVER. Pipes still move, wrap and score. This build is used for scoring and demo work.

## Test plan
- Reset, then `btn_start` pulse → `is_start`=1 two cycles later; `bpos_y`=360, `pippos_x1`=900.
- No flaps after start → `bpos_y`=438 after frame 12, 666 after frame 31, clamped to 670 at frame 32; `is_over`=1 two cycles after that tick; positions then frozen.
- Two `btn_flap` edges within one frame → single flap: `vel`=−10, `bpos_y` decreases by 10 in that frame.
- `PIPE_COLLISION_EN` undefined, bench flapping to hover near 360 → `pippos_x1` reaches 160 at frame 185 and `score`=1 that frame. Pipe 1 wraps at x < 4 to x + 1340 with a gap in 160..620.
- Continue hovering until score 10 → `is_win`=1, FSM in WIN, `score` held at 10. `btn_start` → IDLE with all reset values reloaded.
- Assert `rst` in the same cycle as `frame_tick` during PLAY → all outputs equal reset values next cycle; FSM in IDLE.
